// File: rtl/pkt_formatter_if.sv
// Downstream packet bus between the formatter (master) and the packet sink (slave).
interface pkt_formatter_if #(
  parameter int FIFO_WIDE = 32
);
  logic                 fmt_req;
  logic                 fmt_grant;
  logic                 fmt_valid;
  logic [FIFO_WIDE-1:0] fmt_data;
  logic [1:0]           fmt_chid;
  logic [3:0]           fmt_length;
  logic                 fmt_start;
  logic                 fmt_end;

  modport master (
    output fmt_req, fmt_valid, fmt_data, fmt_chid, fmt_length, fmt_start, fmt_end,
    input  fmt_grant
  );

  modport slave (
    input  fmt_req, fmt_valid, fmt_data, fmt_chid, fmt_length, fmt_start, fmt_end,
    output fmt_grant
  );
endinterface

// File: rtl/pkt_formatter.sv
// Packet formatter: picks a channel FIFO holding a full packet (round-robin),
// requests the downstream bus, then streams the packet words out on grant.
module pkt_formatter #(
  parameter int FIFO_DEPTH    = 8,
  parameter int FIFO_WIDE     = 32,
  parameter int FIFO_PTR_WIDE = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fmt_en,
  input  logic [1:0]             fmt_len,
  input  logic [2:0]             ch_en,
  input  logic [FIFO_WIDE-1:0]   ch0_data_in,
  input  logic [FIFO_WIDE-1:0]   ch1_data_in,
  input  logic [FIFO_WIDE-1:0]   ch2_data_in,
  input  logic [FIFO_PTR_WIDE:0] ch0_slack,
  input  logic [FIFO_PTR_WIDE:0] ch1_slack,
  input  logic [FIFO_PTR_WIDE:0] ch2_slack,
  output logic                   ch0_rd_en,
  output logic                   ch1_rd_en,
  output logic                   ch2_rd_en,
  pkt_formatter_if.master        fmt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] chid_q, chid_d;
  logic [3:0] len_q, len_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] rr_q, rr_d;

  logic [3:0] len_dec;
  logic [2:0] elig;
  logic [2:0] pick;
  logic       last_word;

  // Occupancy test written as slack + need <= depth so a slack larger than the
  // depth can never wrap into a false "enough words" result.
  function automatic logic fits(input logic [FIFO_PTR_WIDE:0] slack, input logic [3:0] need);
    return (int'(slack) + int'(need)) <= FIFO_DEPTH;
  endfunction

  // Returns {found, channel}: first eligible channel searching from 'start', wrapping 2->0.
  function automatic logic [2:0] rr_pick(input logic [2:0] e, input logic [1:0] start);
    logic [2:0] res;
    logic [2:0] pos;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      pos = {1'b0, start} + 3'(k);
      if (pos >= 3'd3) pos = pos - 3'd3;
      if (e[pos[1:0]]) res = {1'b1, pos[1:0]};
    end
    return res;
  endfunction

  assign len_dec   = 4'd1 << fmt_len;
  assign last_word = ({1'b0, cnt_q} == (len_q - 4'd1));

  // Per-channel eligibility and round-robin selection.
  always_comb begin
    elig[0] = ch_en[0] && fits(ch0_slack, len_dec);
    elig[1] = ch_en[1] && fits(ch1_slack, len_dec);
    elig[2] = ch_en[2] && fits(ch2_slack, len_dec);
    pick    = rr_pick(elig, rr_q);
  end

  // Next-state logic: packet parameters are latched at selection so later
  // changes to fmt_len/ch_en/fmt_en never disturb a packet in flight.
  always_comb begin
    state_d = state_q;
    chid_d  = chid_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (fmt_en && pick[2]) begin
          chid_d  = pick[1:0];
          len_d   = len_dec;
          cnt_d   = 3'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fmt.fmt_grant) state_d = SEND;
      end
      SEND: begin
        cnt_d = cnt_q + 3'd1;
        if (last_word) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
          rr_d    = (chid_q == 2'd2) ? 2'd0 : chid_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any packet and restarts the search at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chid_q  <= 2'd0;
      len_q   <= 4'd0;
      cnt_q   <= 3'd0;
      rr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      chid_q  <= chid_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Output decode from the registered state; data passes straight through from the FIFO head.
  always_comb begin
    fmt.fmt_req    = 1'b0;
    fmt.fmt_valid  = 1'b0;
    fmt.fmt_data   = '0;
    fmt.fmt_chid   = 2'd0;
    fmt.fmt_length = 4'd0;
    fmt.fmt_start  = 1'b0;
    fmt.fmt_end    = 1'b0;
    ch0_rd_en      = 1'b0;
    ch1_rd_en      = 1'b0;
    ch2_rd_en      = 1'b0;
    case (state_q)
      REQ: begin
        fmt.fmt_req    = 1'b1;
        fmt.fmt_chid   = chid_q;
        fmt.fmt_length = len_q;
      end
      SEND: begin
        fmt.fmt_valid  = 1'b1;
        fmt.fmt_chid   = chid_q;
        fmt.fmt_length = len_q;
        fmt.fmt_start  = (cnt_q == 3'd0);
        fmt.fmt_end    = last_word;
        case (chid_q)
          2'd0: begin fmt.fmt_data = ch0_data_in; ch0_rd_en = 1'b1; end
          2'd1: begin fmt.fmt_data = ch1_data_in; ch1_rd_en = 1'b1; end
          2'd2: begin fmt.fmt_data = ch2_data_in; ch2_rd_en = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pkt_formatter.md
PKT_FORMATTER -- requirements
Module: pkt_formatter

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entries per upstream channel FIFO.
REQ-002 Parameter FIFO_WIDE, default 32, data word width.
REQ-003 Parameter FIFO_PTR_WIDE, default 3, FIFO address width; slack inputs are FIFO_PTR_WIDE+1 bits.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fmt_en  input  1  formatter enable; gates start of new packets only.
REQ-007 fmt_len  input  2  packet length code: 0->1, 1->2, 2->4, 3->8 words.
REQ-008 ch_en  input  3  per-channel enable, bit N = channel N.
REQ-009 ch0_data_in / ch1_data_in / ch2_data_in  input  FIFO_WIDE each  head word of channel FIFO (show-ahead, valid while FIFO non-empty).
REQ-010 ch0_slack / ch1_slack / ch2_slack  input  FIFO_PTR_WIDE+1 each  free entries in channel FIFO.
REQ-011 ch0_rd_en / ch1_rd_en / ch2_rd_en  output  1 each  pop strobe to channel FIFO; one word consumed per high cycle.
REQ-012 fmt_req  output  1  packet request to downstream.
REQ-013 fmt_grant  input  1  downstream grant, sampled only while fmt_req=1.
REQ-014 fmt_valid  output  1  fmt_data carries a packet word.
REQ-015 fmt_data  output  FIFO_WIDE  packet word.
REQ-016 fmt_chid  output  2  source channel of current packet.
REQ-017 fmt_length  output  4  word count of current packet (1,2,4,8).
REQ-018 fmt_start / fmt_end  output  1 each  first / last word marker, coincident with fmt_valid.

Function
REQ-019 Channel N eligible when ch_en[N]=1 and occupancy (FIFO_DEPTH - chN_slack) >= decoded fmt_len.
REQ-020 States: IDLE, REQ, SEND; exactly one active.
REQ-021 IDLE: if fmt_en=1 and any channel eligible -> select one by round-robin, latch chid and decoded length, go REQ next cycle; else stay.
REQ-022 Round-robin: search starts at channel after last served (wrap 2->0); after reset search starts at channel 0.
REQ-023 REQ: fmt_req=1, fmt_chid/fmt_length hold latched values; fmt_grant=1 at an edge -> SEND; else stay in REQ indefinitely.
REQ-024 SEND: each cycle fmt_valid=1, selected chN_rd_en=1, fmt_data=selected chN_data_in combinationally; word counter increments from 0.
REQ-025 fmt_start=1 on counter=0; fmt_end=1 on counter=length-1; length 1 gives both high in same cycle.
REQ-026 After the fmt_end cycle -> IDLE; round-robin pointer updated to served channel; minimum one IDLE cycle between packets.
REQ-027 No backpressure during SEND: downstream accepts one word per cycle after grant.
REQ-028 fmt_len, ch_en, fmt_en changes after selection do not affect the packet in flight; fmt_en=0 mid-packet lets the packet complete.
REQ-029 fmt_req=0 in IDLE and SEND; fmt_grant outside REQ is ignored.
REQ-030 Never more than one chN_rd_en high; rd_en never asserted outside SEND; occupancy rule guarantees no read from empty FIFO.
REQ-031 Outside SEND: fmt_valid, fmt_start, fmt_end=0 and fmt_data=0.
REQ-032 Counter 3 bits, saturates not required; length 8 uses counter values 0..7.

Reset
REQ-033 rst_n low forces IDLE, counter 0, round-robin pointer to search-from-channel-0, all outputs 0, asynchronously, including mid-REQ or mid-SEND; packet is abandoned, no further rd_en.
REQ-034 After rst_n rises, first packet may be requested no earlier than the first edge evaluating IDLE.

Verification
REQ-035 fmt_len=2, ch1 occupancy 4, others 0, grant 2 cycles after req -> chid=1, length=4, 4 consecutive valid words in FIFO order, start on word 0, end on word 3, ch1_rd_en high exactly 4 cycles.
REQ-036 All three channels occupancy 8, fmt_len=3, grant immediate -> packets served in order chid 0,1,2,0 with one IDLE cycle between.
REQ-037 fmt_len=3, ch0 occupancy 7 -> no fmt_req; one more write (occupancy 8) -> fmt_req next IDLE evaluation.
REQ-038 fmt_len=0, ch2 only -> single-word packet with fmt_start=fmt_end=fmt_valid=1 in one cycle.
REQ-039 rst_n pulsed low at SEND word 2 of 8 -> all outputs 0 immediately, no further rd_en, next packet starts from channel 0 search.
REQ-040 fmt_en dropped during SEND -> current packet completes with all words; no new fmt_req until fmt_en=1.
